// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART receive FIFO: trigger-select encodings and level lookup.
package uart_fifo_pkg;

   typedef enum logic [1:0] {
      TRIG_1  = 2'b00,
      TRIG_Q  = 2'b01,
      TRIG_H  = 2'b10,
      TRIG_F2 = 2'b11
   } trig_sel_e;

   function automatic int unsigned trig_level(input trig_sel_e sel, input int unsigned depth);
      int unsigned lvl;
      case (sel)
         TRIG_1:  lvl = 32'd1;
         TRIG_Q:  lvl = depth / 32'd4;
         TRIG_H:  lvl = depth / 32'd2;
         TRIG_F2: lvl = depth - 32'd2;
         default: lvl = 32'd1;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/uart_dpram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module uart_dpram #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Write port; contents are deliberately never cleared.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rfifo_param.sv
// UART receive FIFO holding {data, err} per character with errored-entry count and trigger detect.
// Character-timeout detection is built only when UART_RFIFO_TIMEOUT_EN is defined.
module uart_rfifo_param
   import uart_fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ERR_W  = 3,
   parameter int DEPTH  = 16,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int CNT_W  = PTR_W + 1,
   parameter int TO_W   = 10
) (
   input  logic                    clk,
   input  logic                    wb_rst_i,
   input  logic                    fifo_reset,
   input  logic                    reset_status,
   input  logic                    push,
   input  logic [DATA_W+ERR_W-1:0] data_in,
   input  logic                    pop,
   output logic [DATA_W+ERR_W-1:0] data_out,
   output logic [CNT_W-1:0]        count,
   output logic                    overrun,
   output logic                    error_bit,
   input  logic [1:0]              trig_lvl,
   output logic                    trig_hit,
   input  logic [TO_W-1:0]         char_time,
   output logic                    timeout
);

   localparam int W = DATA_W + ERR_W;

   logic [PTR_W-1:0] top_r, bottom_r;
   logic [CNT_W-1:0] count_r, err_cnt_r;
   logic             overrun_r;
   logic             full_s, empty_s, push_ok_s, pop_ok_s, err_in_s, err_head_s;
   logic [W-1:0]     head_s;

   uart_dpram #(.WIDTH(W), .DEPTH(DEPTH), .AW(PTR_W)) u_ram (
      .clk   (clk),
      .we    (push_ok_s & ~fifo_reset),
      .waddr (top_r),
      .wdata (data_in),
      .raddr (bottom_r),
      .rdata (head_s)
   );

   // Accept decisions: a pop on a full FIFO frees the slot the same-cycle push uses.
   always_comb begin
      full_s     = (count_r == CNT_W'(DEPTH));
      empty_s    = (count_r == {CNT_W{1'b0}});
      pop_ok_s   = pop & ~empty_s;
      push_ok_s  = push & (~full_s | pop_ok_s);
      err_in_s   = |data_in[ERR_W-1:0];
      err_head_s = |head_s[ERR_W-1:0];
   end

   // Pointers and fill count.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         top_r    <= {PTR_W{1'b0}};
         bottom_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (fifo_reset) begin
         top_r    <= {PTR_W{1'b0}};
         bottom_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_ok_s) top_r    <= top_r + PTR_W'(1);
         if (pop_ok_s)  bottom_r <= bottom_r + PTR_W'(1);
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Running count of held entries whose error field is nonzero.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         err_cnt_r <= {CNT_W{1'b0}};
      end else if (fifo_reset) begin
         err_cnt_r <= {CNT_W{1'b0}};
      end else begin
         case ({push_ok_s & err_in_s, pop_ok_s & err_head_s})
            2'b10:   err_cnt_r <= err_cnt_r + CNT_W'(1);
            2'b01:   err_cnt_r <= err_cnt_r - CNT_W'(1);
            default: err_cnt_r <= err_cnt_r;
         endcase
      end
   end

   // Sticky overrun; a new overrun outranks a status clear in the same cycle.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         overrun_r <= 1'b0;
      end else if (fifo_reset) begin
         overrun_r <= 1'b0;
      end else if (push & full_s & ~pop) begin
         overrun_r <= 1'b1;
      end else if (reset_status) begin
         overrun_r <= 1'b0;
      end else begin
         overrun_r <= overrun_r;
      end
   end

   assign data_out  = head_s;
   assign count     = count_r;
   assign overrun   = overrun_r;
   assign error_bit = (err_cnt_r != {CNT_W{1'b0}});
   assign trig_hit  = ({{(32-CNT_W){1'b0}}, count_r} >= trig_level(trig_sel_e'(trig_lvl), DEPTH));

`ifdef UART_RFIFO_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt_r;
   logic            timeout_r;

   // Idle counter since the last FIFO activity, saturating at the threshold.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         to_cnt_r  <= {TO_W{1'b0}};
         timeout_r <= 1'b0;
      end else begin
         if (fifo_reset | push | pop | empty_s) begin
            to_cnt_r <= {TO_W{1'b0}};
         end else if (to_cnt_r != char_time) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
         end else begin
            to_cnt_r <= to_cnt_r;
         end
         if (fifo_reset | push | pop) begin
            timeout_r <= 1'b0;
         end else if ((char_time != {TO_W{1'b0}}) && (to_cnt_r == char_time) && ~empty_s) begin
            timeout_r <= 1'b1;
         end else begin
            timeout_r <= timeout_r;
         end
      end
   end

   assign timeout = timeout_r;
`else
   logic unused_char_time_s;
   assign unused_char_time_s = ^char_time;
   assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rfifo_param.sv
// Directed self-checking bench for uart_rfifo_param (DEPTH=16, 8 data + 3 error bits).
module tb_uart_rfifo_param;

   localparam int DEPTH = 16;
   localparam int W     = 11;

   logic          clk = 1'b0;
   logic          wb_rst_i, fifo_reset, reset_status, push, pop;
   logic [W-1:0]  data_in;
   logic [W-1:0]  data_out;
   logic [4:0]    count;
   logic          overrun, error_bit, trig_hit, timeout;
   logic [1:0]    trig_lvl;
   logic [9:0]    char_time;

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] model_q[$];

   uart_rfifo_param dut (
      .clk          (clk),
      .wb_rst_i     (wb_rst_i),
      .fifo_reset   (fifo_reset),
      .reset_status (reset_status),
      .push         (push),
      .data_in      (data_in),
      .pop          (pop),
      .data_out     (data_out),
      .count        (count),
      .overrun      (overrun),
      .error_bit    (error_bit),
      .trig_lvl     (trig_lvl),
      .trig_hit     (trig_hit),
      .char_time    (char_time),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic p, input logic q, input logic [W-1:0] d);
      push = p; pop = q; data_in = d;
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [W-1:0] ent(input int i);
      logic [7:0] d;
      d = 8'h10 + 8'(i);
      return {d, (i % 2 == 1) ? 3'b001 : 3'b000};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic       mp, mq, do_pop, do_push, any_err;
      logic [W-1:0] v;
      wb_rst_i = 1'b1; fifo_reset = 1'b0; reset_status = 1'b0;
      push = 1'b0; pop = 1'b0; data_in = '0; trig_lvl = 2'b00; char_time = 10'd0;
      idle(3);
      wb_rst_i = 1'b0;
      idle(1);
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_overrun", 32'(overrun), 32'd0);
      check_eq("rst_error_bit", 32'(error_bit), 32'd0);
      check_eq("rst_trig_hit", 32'(trig_hit), 32'd0);
      check_eq("rst_timeout", 32'(timeout), 32'd0);

      // 1: two characters, second errored
      step(1'b1, 1'b0, {8'h41, 3'd0});
      check_eq("t1_first_visible", 32'(data_out), 32'h208);
      step(1'b1, 1'b0, {8'h42, 3'd4});
      check_eq("t1_count2", 32'(count), 32'd2);
      check_eq("t1_err2", 32'(error_bit), 32'd1);
      step(1'b0, 1'b1, '0);
      check_eq("t1_head", 32'(data_out), 32'h214);
      check_eq("t1_count1", 32'(count), 32'd1);
      check_eq("t1_err1", 32'(error_bit), 32'd1);
      step(1'b0, 1'b1, '0);
      check_eq("t1_count0", 32'(count), 32'd0);
      check_eq("t1_err0", 32'(error_bit), 32'd0);
      step(1'b0, 1'b1, '0);
      check_eq("t1_pop_empty", 32'(count), 32'd0);

      // 2: overfill by one
      for (int i = 0; i <= DEPTH; i++) step(1'b1, 1'b0, ent(i));
      check_eq("t2_count_full", 32'(count), 32'd16);
      check_eq("t2_overrun", 32'(overrun), 32'd1);
      check_eq("t2_err", 32'(error_bit), 32'd1);
      check_eq("t2_head", 32'(data_out), 32'(ent(0)));
      check_eq("t2_trig_f2", 32'(trig_hit), 32'd1);
      reset_status = 1'b1;
      step(1'b0, 1'b0, '0);
      reset_status = 1'b0;
      check_eq("t2_overrun_clr", 32'(overrun), 32'd0);
      check_eq("t2_count_kept", 32'(count), 32'd16);
      // overrun set outranks reset_status
      reset_status = 1'b1;
      step(1'b1, 1'b0, {8'hEE, 3'd0});
      reset_status = 1'b0;
      check_eq("t2_set_wins", 32'(overrun), 32'd1);
      reset_status = 1'b1;
      step(1'b0, 1'b0, '0);
      reset_status = 1'b0;

      // 3: push+pop while full
      step(1'b1, 1'b1, {8'hAA, 3'd4});
      check_eq("t3_count_full", 32'(count), 32'd16);
      check_eq("t3_overrun", 32'(overrun), 32'd0);
      check_eq("t3_head_adv", 32'(data_out), 32'(ent(1)));
      for (int k = 2; k < DEPTH; k++) begin
         step(1'b0, 1'b1, '0);
         check_eq($sformatf("t3_order%0d", k), 32'(data_out), 32'(ent(k)));
      end
      step(1'b0, 1'b1, '0);
      check_eq("t3_last", 32'(data_out), 32'h554);
      check_eq("t3_last_err", 32'(error_bit), 32'd1);
      step(1'b0, 1'b1, '0);
      check_eq("t3_drained", 32'(count), 32'd0);
      check_eq("t3_drained_err", 32'(error_bit), 32'd0);
      step(1'b1, 1'b1, {8'h55, 3'd0});
      check_eq("t3_empty_pp_count", 32'(count), 32'd1);
      check_eq("t3_empty_pp_data", 32'(data_out), 32'h2A8);
      step(1'b0, 1'b1, '0);

      // 4: mixed traffic wrapping the pointers, checked against a queue model
      for (int i = 0; i < 3 * DEPTH; i++) begin
         mp = (i % 3 != 2);
         mq = (i % 2 == 1);
         v  = {8'(i * 7), (i % 5 == 0) ? 3'b010 : 3'b000};
         do_pop  = mq && (model_q.size() > 0);
         do_push = mp && ((model_q.size() < DEPTH) || do_pop);
         step(mp, mq, v);
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back(v);
         any_err = 1'b0;
         foreach (model_q[j]) if (model_q[j][2:0] != 3'b000) any_err = 1'b1;
         check_eq($sformatf("t4_count%0d", i), 32'(count), 32'(model_q.size()));
         check_eq($sformatf("t4_err%0d", i), 32'(error_bit), 32'(any_err));
         if (model_q.size() > 0)
            check_eq($sformatf("t4_head%0d", i), 32'(data_out), 32'(model_q[0]));
      end
      while (model_q.size() > 0) begin
         check_eq("t4_drain", 32'(data_out), 32'(model_q[0]));
         step(1'b0, 1'b1, '0);
         void'(model_q.pop_front());
      end
      check_eq("t4_empty", 32'(count), 32'd0);
      check_eq("t4_empty_err", 32'(error_bit), 32'd0);

      // 5: trigger levels and flush
      trig_lvl = 2'b10;
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, {8'(i), 3'd1});
      check_eq("t5_half_7", 32'(trig_hit), 32'd0);
      step(1'b1, 1'b0, {8'h07, 3'd0});
      check_eq("t5_half_8", 32'(trig_hit), 32'd1);
      trig_lvl = 2'b11; #1;
      check_eq("t5_f2_8", 32'(trig_hit), 32'd0);
      trig_lvl = 2'b01; #1;
      check_eq("t5_q_8", 32'(trig_hit), 32'd1);
      trig_lvl = 2'b00;
      fifo_reset = 1'b1;
      step(1'b1, 1'b0, {8'h99, 3'd7});
      fifo_reset = 1'b0;
      check_eq("t5_flush_count", 32'(count), 32'd0);
      check_eq("t5_flush_err", 32'(error_bit), 32'd0);
      check_eq("t5_flush_trig", 32'(trig_hit), 32'd0);

      // 6: character timeout
      char_time = 10'd20;
      step(1'b1, 1'b0, {8'h33, 3'd0});
`ifdef UART_RFIFO_TIMEOUT_EN
      idle(19);
      check_eq("t6_not_yet", 32'(timeout), 32'd0);
      idle(2);
      check_eq("t6_timeout", 32'(timeout), 32'd1);
      step(1'b0, 1'b1, '0);
      check_eq("t6_cleared", 32'(timeout), 32'd0);
      idle(30);
      check_eq("t6_empty_idle", 32'(timeout), 32'd0);
`else
      idle(30);
      check_eq("t6_disabled", 32'(timeout), 32'd0);
      step(1'b0, 1'b1, '0);
`endif
      check_eq("t6_count", 32'(count), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
